distri_ram_mp: RTL and testbench

//  Multi-read-port distributed RAM with byte-lane writes, per-entry valid bits and a

---
 rtl/distri_ram_mp_pkg.sv | 15 +
 rtl/distri_ram_mp_clear_ctrl.sv | 54 +++++
 rtl/distri_ram_mp.sv | 143 ++++++++++++++
 tb/tb_distri_ram_mp.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/distri_ram_mp_pkg.sv
// Shared definitions for the multi-port distributed RAM: clear-sequencer state
// encodings and the address bounds check used by every port.
package distri_ram_mp_pkg;

    typedef logic [0:0] dram_state_t;

    localparam dram_state_t DRAM_CLEAR = 1'b0;
    localparam dram_state_t DRAM_IDLE  = 1'b1;

    // Addresses at or beyond the entry count never touch the array.
    function automatic logic in_range(input int addr, input int num);
        return addr < num;
    endfunction

endpackage

// File: rtl/distri_ram_mp_clear_ctrl.sv
// Clear sequencer: walks every entry once after reset or flush, then reports ready.
module distri_ram_mp_clear_ctrl
    import distri_ram_mp_pkg::*;
#(
    parameter int ENTRY_NUM = 32,
    parameter int AWIDTH    = $clog2(ENTRY_NUM)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    output logic              ready,
    output logic              clr_we,
    output logic [AWIDTH-1:0] clr_addr
);

    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(ENTRY_NUM - 1);

    dram_state_t       state_reg;
    dram_state_t       state_next;
    logic [AWIDTH-1:0] clr_idx_reg;
    logic [AWIDTH-1:0] clr_idx_next;

    // A flush always restarts the walk from entry 0, even in the middle of a clear.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        if (flush_i) begin
            state_next   = DRAM_CLEAR;
            clr_idx_next = '0;
        end else if (state_reg == DRAM_CLEAR) begin
            if (clr_idx_reg == LAST_IDX) begin
                state_next   = DRAM_IDLE;
                clr_idx_next = '0;
            end else begin
                clr_idx_next = clr_idx_reg + AWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= DRAM_CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    assign ready    = (state_reg == DRAM_IDLE);
    assign clr_we   = (state_reg == DRAM_CLEAR);
    assign clr_addr = clr_idx_reg;

endmodule

// File: rtl/distri_ram_mp.sv
// Multi-read-port distributed RAM with byte-lane writes, per-entry valid bits,
// optional write-to-read bypass and optional registered outputs.
module distri_ram_mp
    import distri_ram_mp_pkg::*;
#(
    parameter int ENTRY_NUM = 32,
    parameter int XLEN      = 64,
    parameter int NRD       = 2,
    parameter int REG_OUT   = 0,
    parameter int WR_BYPASS = 1,
    parameter int AWIDTH    = $clog2(ENTRY_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    input  logic                  we_i,
    input  logic [XLEN/8-1:0]     wstrb_i,
    input  logic [AWIDTH-1:0]     write_addr_i,
    input  logic [XLEN-1:0]       data_i,
    input  logic [NRD*AWIDTH-1:0] read_addr_i,
    output logic [NRD*XLEN-1:0]   data_o,
    output logic [NRD-1:0]        valid_o
);

    localparam int NBYTES = XLEN / 8;

    logic                ready;
    logic                clr_we;
    logic [AWIDTH-1:0]   clr_addr;

    logic [XLEN-1:0]     ram [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] valid_reg;

    logic                wr_in_range;
    logic                user_we;
    logic                ram_we;
    logic [AWIDTH-1:0]   ram_addr;
    logic [XLEN-1:0]     ram_wdata;
    logic [NBYTES-1:0]   ram_strb;
    logic [XLEN-1:0]     wr_old;
    logic [XLEN-1:0]     wr_merged;

    distri_ram_mp_clear_ctrl #(
        .ENTRY_NUM (ENTRY_NUM),
        .AWIDTH    (AWIDTH)
    ) u_clear_ctrl (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign ready_o = ready;

    // User writes are accepted only when idle, not flushing, and in bounds.
    assign wr_in_range = in_range(int'(write_addr_i), ENTRY_NUM);
    assign user_we     = we_i & ready & ~flush_i & wr_in_range;

    assign ram_we    = clr_we | user_we;
    assign ram_addr  = clr_we ? clr_addr : write_addr_i;
    assign ram_wdata = clr_we ? '0 : data_i;
    assign ram_strb  = clr_we ? '1 : wstrb_i;

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (ram_strb[b]) begin
                    ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end
    end

    // The valid bit is set by any accepted write, even with all strobes low.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            valid_reg[ram_addr] <= ~clr_we;
        end
    end

    // Byte-merged image of the entry being written, used by the bypass path.
    assign wr_old = wr_in_range ? ram[write_addr_i] : '0;

    always_comb begin
        wr_merged = wr_old;
        for (int b = 0; b < NBYTES; b++) begin
            if (wstrb_i[b]) begin
                wr_merged[b*8 +: 8] = data_i[b*8 +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AWIDTH-1:0] rd_addr;
        logic              rd_hit;
        logic              rd_byp;
        logic [XLEN-1:0]   rd_data;
        logic              rd_valid;

        assign rd_addr = read_addr_i[gi*AWIDTH +: AWIDTH];
        assign rd_hit  = in_range(int'(rd_addr), ENTRY_NUM);
        assign rd_byp  = (WR_BYPASS != 0) && user_we && (rd_addr == write_addr_i);

        always_comb begin
            rd_data  = '0;
            rd_valid = 1'b0;
            if (ready && rd_hit) begin
                if (rd_byp) begin
                    rd_data  = wr_merged;
                    rd_valid = 1'b1;
                end else begin
                    rd_data  = ram[rd_addr];
                    rd_valid = valid_reg[rd_addr];
                end
            end
        end

        if (REG_OUT != 0) begin : g_reg
            logic [XLEN-1:0] out_data_reg;
            logic            out_valid_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    out_data_reg  <= '0;
                    out_valid_reg <= 1'b0;
                end else begin
                    out_data_reg  <= rd_data;
                    out_valid_reg <= rd_valid;
                end
            end

            assign data_o[gi*XLEN +: XLEN] = out_data_reg;
            assign valid_o[gi]             = out_valid_reg;
        end else begin : g_comb
            assign data_o[gi*XLEN +: XLEN] = rd_data;
            assign valid_o[gi]             = rd_valid;
        end
    end

endmodule

// File: tb/tb_distri_ram_mp.sv
// Directed bench: five configurations driven from one shared write/flush stimulus.
module tb_distri_ram_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         we;
    logic [7:0]   wstrb;
    logic [4:0]   waddr;
    logic [63:0]  wdata;
    logic [9:0]   raddr;
    logic [14:0]  raddr_e;

    logic         rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
    logic [127:0] dout_a, dout_b, dout_c, dout_d;
    logic [191:0] dout_e;
    logic [1:0]   vld_a, vld_b, vld_c, vld_d;
    logic [2:0]   vld_e;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cnt;

    always #5 clk = ~clk;

    // A: async + bypass, B: async read-first, C: registered + bypass, D: registered read-first
    distri_ram_mp #(.ENTRY_NUM(32), .XLEN(64), .NRD(2), .REG_OUT(0), .WR_BYPASS(1)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(rdy_a), .we_i(we), .wstrb_i(wstrb),
        .write_addr_i(waddr), .data_i(wdata), .read_addr_i(raddr), .data_o(dout_a), .valid_o(vld_a));
    distri_ram_mp #(.ENTRY_NUM(32), .XLEN(64), .NRD(2), .REG_OUT(0), .WR_BYPASS(0)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(rdy_b), .we_i(we), .wstrb_i(wstrb),
        .write_addr_i(waddr), .data_i(wdata), .read_addr_i(raddr), .data_o(dout_b), .valid_o(vld_b));
    distri_ram_mp #(.ENTRY_NUM(32), .XLEN(64), .NRD(2), .REG_OUT(1), .WR_BYPASS(1)) u_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(rdy_c), .we_i(we), .wstrb_i(wstrb),
        .write_addr_i(waddr), .data_i(wdata), .read_addr_i(raddr), .data_o(dout_c), .valid_o(vld_c));
    distri_ram_mp #(.ENTRY_NUM(32), .XLEN(64), .NRD(2), .REG_OUT(1), .WR_BYPASS(0)) u_d (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(rdy_d), .we_i(we), .wstrb_i(wstrb),
        .write_addr_i(waddr), .data_i(wdata), .read_addr_i(raddr), .data_o(dout_d), .valid_o(vld_d));
    distri_ram_mp #(.ENTRY_NUM(24), .XLEN(64), .NRD(3), .REG_OUT(0), .WR_BYPASS(1)) u_e (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ready_o(rdy_e), .we_i(we), .wstrb_i(wstrb),
        .write_addr_i(waddr), .data_i(wdata), .read_addr_i(raddr_e), .data_o(dout_e), .valid_o(vld_e));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive sampled cycles with u_a not ready, bounded.
    task automatic count_clear(output int n);
        n = 0;
        while (rdy_a !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; we = 1'b0; wstrb = '0; waddr = '0; wdata = '0;
        raddr = '0; raddr_e = '0;
        tick();
        rst = 1'b0;
        $display("txn reset released");
        chk("reset_ready", 64'(rdy_a), 64'd0);
        chk("reset_data_a", dout_a[63:0] | dout_a[127:64], 64'd0);
        chk("reset_valid_a", 64'(vld_a), 64'd0);
        chk("reset_data_c", dout_c[63:0] | dout_c[127:64], 64'd0);
        chk("reset_valid_c", 64'(vld_c), 64'd0);
        count_clear(cnt);
        chk("reset_clear_len", 64'(cnt), 64'd32);
        chk("ready_c", 64'(rdy_c), 64'd1);
        chk("ready_e", 64'(rdy_e), 64'd1);
        raddr = {5'd5, 5'd3};
        #1;
        chk("cleared_data", dout_a[63:0] | dout_a[127:64], 64'd0);
        chk("cleared_valid", 64'(vld_a), 64'd0);

        // Byte-lane write: full word, then low four lanes only
        $display("txn write addr 5 full then low lanes");
        raddr = '0; we = 1'b1; waddr = 5'd5; wdata = 64'h1122334455667788; wstrb = 8'hFF;
        tick();
        wdata = 64'hAAAAAAAAAAAAAAAA; wstrb = 8'h0F;
        tick();
        we = 1'b0; raddr = {5'd5, 5'd5}; raddr_e = {5'd5, 5'd5, 5'd5};
        #1;
        chk("bytewr_p0", dout_a[63:0], 64'h11223344AAAAAAAA);
        chk("bytewr_p1", dout_a[127:64], 64'h11223344AAAAAAAA);
        chk("bytewr_valid", 64'(vld_a), 64'd3);
        chk("bytewr_e_p2", dout_e[191:128], 64'h11223344AAAAAAAA);
        tick();
        chk("bytewr_reg_c", dout_c[63:0], 64'h11223344AAAAAAAA);
        chk("bytewr_reg_valid_c", 64'(vld_c), 64'd3);

        // Zero strobes still mark the entry valid
        $display("txn write addr 12 strobes 0");
        we = 1'b1; waddr = 5'd12; wdata = '1; wstrb = 8'h00;
        tick();
        we = 1'b0; raddr = {5'd0, 5'd12};
        #1;
        chk("nostrb_data", dout_a[63:0], 64'd0);
        chk("nostrb_valid", 64'(vld_a[0]), 64'd1);

        // Bypass on port 1 reading addr 3 during the write
        $display("txn write addr 3 with port1 reading 3");
        raddr = {5'd3, 5'd5}; we = 1'b1; waddr = 5'd3; wdata = 64'hDEAD; wstrb = 8'hFF;
        #1;
        chk("byp_a_p1", dout_a[127:64], 64'hDEAD);
        chk("byp_a_v1", 64'(vld_a[1]), 64'd1);
        chk("byp_a_p0", dout_a[63:0], 64'h11223344AAAAAAAA);
        chk("nobyp_b_p1", dout_b[127:64], 64'd0);
        chk("nobyp_b_v1", 64'(vld_b[1]), 64'd0);
        tick();
        we = 1'b0;
        #1;
        chk("nobyp_b_next", dout_b[127:64], 64'hDEAD);
        chk("nobyp_b_next_v", 64'(vld_b[1]), 64'd1);
        chk("regbyp_c_p1", dout_c[127:64], 64'hDEAD);
        chk("regnobyp_d_p1", dout_d[127:64], 64'd0);
        chk("regnobyp_d_v1", 64'(vld_d[1]), 64'd0);
        tick();
        chk("regnobyp_d_later", dout_d[127:64], 64'hDEAD);

        // Registered latency at addr 7 with a same-edge write
        $display("txn write addr 7 with port0 reading 7");
        raddr = {5'd3, 5'd7}; we = 1'b1; waddr = 5'd7; wdata = 64'h0123456789ABCDEF; wstrb = 8'hFF;
        #1;
        chk("reg_c_before_edge", dout_c[63:0], 64'h11223344AAAAAAAA);
        tick();
        we = 1'b0;
        chk("reg_c_t1", dout_c[63:0], 64'h0123456789ABCDEF);
        chk("reg_d_t1", dout_d[63:0], 64'd0);
        tick();
        chk("reg_d_t2", dout_d[63:0], 64'h0123456789ABCDEF);

        // Multi-port reads on the 24-entry, 3-port instance
        $display("txn write addr 9, three ports read 9");
        we = 1'b1; waddr = 5'd9; wdata = 64'h0909090909090909; wstrb = 8'hFF;
        tick();
        we = 1'b0; raddr_e = {5'd9, 5'd9, 5'd9};
        #1;
        chk("mp_p0", dout_e[63:0], 64'h0909090909090909);
        chk("mp_p1", dout_e[127:64], 64'h0909090909090909);
        chk("mp_p2", dout_e[191:128], 64'h0909090909090909);
        chk("mp_valid", 64'(vld_e), 64'd7);

        // Out-of-range write and read on the 24-entry instance
        $display("txn write addr 30 out of range");
        we = 1'b1; waddr = 5'd30; wdata = '1; wstrb = 8'hFF; raddr_e = {5'd30, 5'd9, 5'd5};
        #1;
        chk("oob_during_wr", dout_e[191:128], 64'd0);
        tick();
        we = 1'b0;
        chk("oob_data", dout_e[191:128], 64'd0);
        chk("oob_valid", 64'(vld_e), 64'd3);
        chk("oob_p1_intact", dout_e[127:64], 64'h0909090909090909);
        chk("oob_p0_intact", dout_e[63:0], 64'h11223344AAAAAAAA);

        // Flush from idle, restarted at clear cycle 10
        $display("txn flush from idle");
        raddr = {5'd3, 5'd5}; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", 64'(rdy_a), 64'd0);
        chk("flush_valid", 64'(vld_a), 64'd0);
        chk("flush_data", dout_a[63:0] | dout_a[127:64], 64'd0);
        for (int i = 1; i < 10; i++) tick();
        $display("txn flush restart with write at clear cycle 10");
        flush = 1'b1; we = 1'b1; waddr = 5'd5; wdata = '1; wstrb = 8'hFF;
        tick();
        flush = 1'b0; we = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        $display("txn write addr 0 during clear");
        we = 1'b1; waddr = 5'd0; wdata = 64'h5555; wstrb = 8'hFF;
        tick();
        we = 1'b0;
        count_clear(cnt);
        chk("flush_restart_len", 64'(cnt + 5), 64'd32);
        raddr = {5'd5, 5'd0};
        #1;
        chk("clear_wr_ignored_v", 64'(vld_a), 64'd0);
        chk("clear_wr_ignored_d", dout_a[63:0], 64'd0);

        // Write together with flush is dropped
        $display("txn write addr 0 together with flush");
        we = 1'b1; flush = 1'b1; waddr = 5'd0; wdata = 64'h1234; wstrb = 8'hFF;
        #1;
        chk("wrflush_no_bypass", 64'(vld_a[0]), 64'd0);
        tick();
        we = 1'b0; flush = 1'b0;
        count_clear(cnt);
        chk("wrflush_clear_len", 64'(cnt), 64'd32);
        chk("wrflush_valid", 64'(vld_a), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
